// File: rtl/jt900h_memwr.sv
// jt900h_memwr: write-back sequencer for ALU results going to memory.
// Splits a byte/word/long result into little-endian 16-bit bus pieces,
// runs the bus_cs/bus_ok handshake and pulses done (with err for bad widths).
// Optional feature macro: JT900H_WR_BUF_EN adds a one-entry request buffer so a
// new request can be queued while the bus is busy and issued back-to-back.
module jt900h_memwr #(
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          start,
  input  logic [2:0]    w,
  input  logic [31:0]   din,
  input  logic [AW-1:0] addr,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          bus_cs,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   bus_dout,
  output logic [1:0]    bus_we,
  input  logic          bus_ok
);

  typedef enum logic { IDLE, BUS } state_t;

  typedef struct packed {
    logic [2:0]    w;
    logic [31:0]   d;
    logic [AW-1:0] a;
  } req_t;

  state_t      state, state_nx;
  req_t        cur, cur_nx;
  logic [1:0]  pc, pc_nx;
  logic        done_nx, err_nx;
  logic        take, launch;
  req_t        launch_req, in_req;

`ifdef JT900H_WR_BUF_EN
  req_t        pend, pend_nx;
  logic        pend_full, pend_full_nx;
`endif

  logic [7:0]    b0, b1, b2, b3;
  logic [AW-1:0] p_addr;
  logic [1:0]    p_we;
  logic [15:0]   p_dout;
  logic          p_last;

  function automatic logic onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  assign {b3, b2, b1, b0} = cur.d;
  assign in_req = {w, din, addr};

`ifdef JT900H_WR_BUF_EN
  assign busy = pend_full;
`else
  assign busy = (state != IDLE);
`endif

  assign take = start & ~busy;

  // Decode the current piece (address, lane enables, data, last flag) from the
  // latched request and piece counter; unused lanes carry the same byte.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    p_addr = cur.a;
    p_we   = 2'b00;
    p_dout = 16'h0000;
    p_last = 1'b1;
    if (cur.w[0]) begin
      p_we   = cur.a[0] ? 2'b10 : 2'b01;
      p_dout = {b0, b0};
    end else if (cur.w[1]) begin
      if (!cur.a[0]) begin
        p_we   = 2'b11;
        p_dout = {b1, b0};
      end else if (pc == 2'd0) begin
        p_we   = 2'b10;
        p_dout = {b0, b0};
        p_last = 1'b0;
      end else begin
        p_addr = cur.a + AW'(1);
        p_we   = 2'b01;
        p_dout = {b1, b1};
      end
    end else begin
      if (!cur.a[0]) begin
        p_we = 2'b11;
        if (pc == 2'd0) begin
          p_dout = {b1, b0};
          p_last = 1'b0;
        end else begin
          p_addr = cur.a + AW'(2);
          p_dout = {b3, b2};
        end
      end else begin
        case (pc)
          2'd0: begin
            p_we   = 2'b10;
            p_dout = {b0, b0};
            p_last = 1'b0;
          end
          2'd1: begin
            p_addr = cur.a + AW'(1);
            p_we   = 2'b11;
            p_dout = {b2, b1};
            p_last = 1'b0;
          end
          default: begin
            p_addr = cur.a + AW'(3);
            p_we   = 2'b01;
            p_dout = {b3, b3};
          end
        endcase
      end
    end
  end

  // Bus outputs are driven only while a piece is active; zero otherwise.
  always_comb begin
    bus_cs   = (state == BUS);
    bus_addr = bus_cs ? p_addr : '0;
    bus_we   = bus_cs ? p_we   : 2'b00;
    bus_dout = bus_cs ? p_dout : 16'h0000;
  end

  // Next-state logic: accept/launch requests, advance pieces, raise done/err.
  always_comb begin
    state_nx   = state;
    cur_nx     = cur;
    pc_nx      = pc;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    launch     = 1'b0;
    launch_req = in_req;
`ifdef JT900H_WR_BUF_EN
    pend_nx      = pend;
    pend_full_nx = pend_full;
`endif
    case (state)
      IDLE: begin
`ifdef JT900H_WR_BUF_EN
        if (pend_full) begin
          launch       = 1'b1;
          launch_req   = pend;
          pend_full_nx = 1'b0;
        end else
`endif
        if (take) launch = 1'b1;
      end
      BUS: begin
        if (bus_ok && p_last) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
`ifdef JT900H_WR_BUF_EN
          // A valid queued request starts on the very next cycle; an invalid
          // one waits in the buffer so its own done/err pulse stays separate.
          if (pend_full) begin
            if (onehot(pend.w)) begin
              launch       = 1'b1;
              launch_req   = pend;
              pend_full_nx = 1'b0;
            end
          end else if (take) begin
            if (onehot(w)) begin
              launch = 1'b1;
            end else begin
              pend_nx      = in_req;
              pend_full_nx = 1'b1;
            end
          end
`endif
        end else begin
          if (bus_ok) pc_nx = pc + 2'd1;
`ifdef JT900H_WR_BUF_EN
          if (take) begin
            pend_nx      = in_req;
            pend_full_nx = 1'b1;
          end
`endif
        end
      end
      default: state_nx = IDLE;
    endcase
    if (launch) begin
      cur_nx = launch_req;
      pc_nx  = 2'd0;
      if (onehot(launch_req.w)) begin
        state_nx = BUS;
      end else begin
        state_nx = IDLE;
        done_nx  = 1'b1;
        err_nx   = 1'b1;
      end
    end
  end

  // State register: synchronous reset, otherwise advances only on cen.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the request buffer is a handful of flops, so it is reset with the rest to keep outputs deterministic.
      state <= IDLE;
      cur   <= '0;
      pc    <= 2'd0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef JT900H_WR_BUF_EN
      pend      <= '0;
      pend_full <= 1'b0;
`endif
    end else if (cen) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nx;
      cur   <= cur_nx;
      pc    <= pc_nx;
      done  <= done_nx;
      err   <= err_nx;
`ifdef JT900H_WR_BUF_EN
      pend      <= pend_nx;
      pend_full <= pend_full_nx;
`endif
    end
  end

endmodule

// File: tb/tb_jt900h_memwr.sv
// tb_jt900h_memwr: directed bench for jt900h_memwr with a queue-based model of
// the expected bus pieces and done/err pulses, compared on every negedge.
module tb_jt900h_memwr;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst, cen, start, bus_ok;
  logic [2:0]    w;
  logic [31:0]   din;
  logic [AW-1:0] addr;
  logic          busy, done, err, bus_cs;
  logic [AW-1:0] bus_addr;
  logic [15:0]   bus_dout;
  logic [1:0]    bus_we;

  always #5 clk = ~clk;

  jt900h_memwr #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .cen(cen), .start(start), .w(w), .din(din),
    .addr(addr), .busy(busy), .done(done), .err(err), .bus_cs(bus_cs),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_we(bus_we), .bus_ok(bus_ok)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    we;
    logic [15:0]   d;
  } piece_t;

  typedef struct {
    logic [2:0]    w;
    logic [31:0]   d;
    logic [AW-1:0] a;
  } req_t;

  piece_t q[$];
  req_t   mbuf;
  bit     mbuf_full = 0;
  bit     m_done = 0, m_err = 0;
  int     checks = 0, errors = 0;
  bit     cmp_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit valid_w(input logic [2:0] v);
    return $countones(v) == 1;
  endfunction

  // Expand a request into bus pieces: bytes at a+i, an even address with a
  // following byte pairs into one word, anything else is a single lane.
  function automatic void load(input req_t r);
    int n;
    int i;
    logic [7:0]    b[4];
    logic [AW-1:0] ai;
    n = (r.w == 3'b001) ? 1 : (r.w == 3'b010) ? 2 : 4;
    for (int k = 0; k < 4; k++) b[k] = r.d[8*k +: 8];
    i = 0;
    while (i < n) begin
      ai = r.a + AW'(i);
      if (!ai[0] && (i + 1 < n)) begin
        q.push_back('{a: ai, we: 2'b11, d: {b[i+1], b[i]}});
        i += 2;
      end else begin
        q.push_back('{a: ai, we: (ai[0] ? 2'b10 : 2'b01), d: {b[i], b[i]}});
        i += 1;
      end
    end
  endfunction

  function automatic void launch(input req_t r, inout bit nd, inout bit ne);
    if (valid_w(r.w)) load(r);
    else begin
      nd = 1;
      ne = 1;
    end
  endfunction

  // Reference model, stepped on each clock edge from the sampled inputs.
  always @(posedge clk) begin : model
    req_t inr, cand;
    bit had, was_busy, take, completed, nd, ne;
    if (rst) begin
      q.delete();
      mbuf_full = 0;
      m_done = 0;
      m_err = 0;
    end else if (cen) begin
      inr = '{w: w, d: din, a: addr};
      had = (q.size() != 0);
`ifdef JT900H_WR_BUF_EN
      was_busy = mbuf_full;
`else
      was_busy = had;
`endif
      take = start && !was_busy;
      nd = 0;
      ne = 0;
      completed = 0;
      if (had && bus_ok) begin
        q.delete(0);
        completed = (q.size() == 0);
        nd = completed;
      end
`ifdef JT900H_WR_BUF_EN
      if (completed) begin
        if (mbuf_full || take) begin
          cand = mbuf_full ? mbuf : inr;
          if (valid_w(cand.w)) begin
            load(cand);
            mbuf_full = 0;
          end else begin
            mbuf = cand;
            mbuf_full = 1;
          end
        end
      end else if (had) begin
        if (take) begin
          mbuf = inr;
          mbuf_full = 1;
        end
      end else if (mbuf_full) begin
        launch(mbuf, nd, ne);
        mbuf_full = 0;
      end else if (take) begin
        launch(inr, nd, ne);
      end
`else
      if (!had && take) launch(inr, nd, ne);
`endif
      m_done = nd;
      m_err = ne;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
`ifdef JT900H_WR_BUF_EN
      check("busy", busy, mbuf_full);
`else
      check("busy", busy, q.size() != 0);
`endif
      check("done", done, m_done);
      if (m_done) check("err", err, m_err);
      check("bus_cs", bus_cs, q.size() != 0);
      if (q.size() != 0) begin
        check("bus_addr", bus_addr, q[0].a);
        check("bus_we", bus_we, q[0].we);
        check("bus_dout", bus_dout, q[0].d);
      end else begin
        check("bus_we_idle", bus_we, 2'b00);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic [2:0] rw, input logic [31:0] rd, input logic [AW-1:0] ra);
    start = 1'b1;
    w = rw;
    din = rd;
    addr = ra;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((bus_cs || busy || done) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: still active after %0d cycles", n);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; start = 1'b0; bus_ok = 1'b1;
    w = 3'b000; din = 32'h0; addr = '0;
    tick(); tick();
    rst = 1'b0;
    cmp_en = 1;
    check("rst_busy", busy, 1'b0);
    check("rst_bus_cs", bus_cs, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_bus_addr", bus_addr, 24'h000000);
    check("rst_bus_dout", bus_dout, 16'h0000);
    tick();

    // Odd byte.
    req(3'b001, 32'h1234565A, 24'h000101);
    check("byte_cs", bus_cs, 1'b1);
    check("byte_addr", bus_addr, 24'h000101);
    check("byte_we", bus_we, 2'b10);
    check("byte_dout", bus_dout, 16'h5A5A);
    tick();
    check("byte_done", done, 1'b1);
    check("byte_err", err, 1'b0);
    check("byte_cs_off", bus_cs, 1'b0);
    drain(20);

    // Aligned word.
    req(3'b010, 32'h00001234, 24'h000200);
    check("word_we", bus_we, 2'b11);
    check("word_dout", bus_dout, 16'h1234);
    tick();
    check("word_done", done, 1'b1);
    check("word_err", err, 1'b0);
    drain(20);

    // Misaligned long with two wait states on the middle piece.
    req(3'b100, 32'hAABBCCDD, 24'h000301);
    check("l1_addr", bus_addr, 24'h000301);
    check("l1_we", bus_we, 2'b10);
    check("l1_dout", bus_dout, 16'hDDDD);
    tick();
    check("l2_addr_a", bus_addr, 24'h000302);
    check("l2_dout", bus_dout, 16'hBBCC);
    bus_ok = 1'b0;
    tick();
    check("l2_addr_b", bus_addr, 24'h000302);
    tick();
    check("l2_addr_c", bus_addr, 24'h000302);
    bus_ok = 1'b1;
    tick();
    check("l3_addr", bus_addr, 24'h000304);
    check("l3_we", bus_we, 2'b01);
    check("l3_dout", bus_dout, 16'hAAAA);
    tick();
    check("long_done", done, 1'b1);
    drain(20);

    // Aligned long wrapping past the top of the address space.
    req(3'b100, 32'h11223344, 24'hFFFFFE);
    check("wrap1_addr", bus_addr, 24'hFFFFFE);
    check("wrap1_dout", bus_dout, 16'h3344);
    tick();
    check("wrap2_addr", bus_addr, 24'h000000);
    check("wrap2_dout", bus_dout, 16'h1122);
    drain(20);

    // Misaligned word at the last address.
    req(3'b010, 32'h0000BEEF, 24'hFFFFFF);
    drain(20);

    // Invalid widths.
    req(3'b011, 32'h55555555, 24'h000010);
    check("inv3_done", done, 1'b1);
    check("inv3_err", err, 1'b1);
    check("inv3_cs", bus_cs, 1'b0);
    drain(20);
    req(3'b000, 32'h55555555, 24'h000010);
    check("inv0_done", done, 1'b1);
    check("inv0_err", err, 1'b1);
    drain(20);

    // Clock-enable stalls mid-request.
    req(3'b100, 32'h0F1E2D3C, 24'h000401);
    for (int i = 0; i < 10; i++) begin
      cen = (i % 2 == 1);
      tick();
    end
    cen = 1'b1;
    drain(20);

    // Start while the bus is busy.
    req(3'b100, 32'h01020304, 24'h000500);
    start = 1'b1; w = 3'b001; din = 32'h00000077; addr = 24'h000600;
    tick();
    start = 1'b0;
    drain(30);

    // Back-to-back starts.
    start = 1'b1; w = 3'b010; din = 32'h0000A1B2; addr = 24'h000701;
    tick();
    w = 3'b100; din = 32'hC3D4E5F6; addr = 24'h000800;
    tick();
    start = 1'b0;
    drain(30);

    // Start on the done cycle.
    req(3'b001, 32'h00000042, 24'h000900);
    tick();
    start = 1'b1; w = 3'b010; din = 32'h00009988; addr = 24'h000A00;
    tick();
    start = 1'b0;
    drain(30);

    // Reset during the second piece.
    req(3'b100, 32'hDEADBEEF, 24'h000301);
    tick();
    rst = 1'b1;
    tick();
    check("rst_mid_cs", bus_cs, 1'b0);
    rst = 1'b0;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
